// File: rtl/trap_csr_if.sv
// Bundles the trap/MRET requests, CSR access port and fetch-redirect outputs of trap_csr_unit.
// The pipeline side (execute/trap handler/fetch) uses master; the trap unit uses slave.
interface trap_csr_if #(
    parameter int XLEN = 32
);
    logic            i_exception;
    logic [XLEN-1:0] i_mcause;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_tval;
    logic            i_mret;
    logic            i_csr_we;
    logic            i_csr_re;
    logic [11:0]     i_csr_addr;
    logic [XLEN-1:0] i_csr_wdata;
    logic [XLEN-1:0] o_csr_rdata;
    logic            o_csr_illegal;
    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;
    logic            o_flush;
    logic            o_stall;
    logic            o_mie;

    modport master (
        output i_exception, i_mcause, i_pc, i_tval, i_mret,
               i_csr_we, i_csr_re, i_csr_addr, i_csr_wdata,
        input  o_csr_rdata, o_csr_illegal, o_redirect, o_redirect_pc,
               o_flush, o_stall, o_mie
    );

    modport slave (
        input  i_exception, i_mcause, i_pc, i_tval, i_mret,
               i_csr_we, i_csr_re, i_csr_addr, i_csr_wdata,
        output o_csr_rdata, o_csr_illegal, o_redirect, o_redirect_pc,
               o_flush, o_stall, o_mie
    );
endinterface

// File: rtl/trap_csr_unit.sv
// M-mode trap entry / MRET return controller owning the machine trap CSRs.
// One-cycle ENTER/RETURN states drive the fetch redirect, flush and stall.
module trap_csr_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = 'h100
) (
    input  logic       clk,
    input  logic       rst,
    trap_csr_if.slave  bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;

    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;

    state_t          state, state_nxt;
    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;

    logic            csr_hit;
    logic [XLEN-1:0] csr_rdata;
    logic            is_idle, take_trap, take_ret, csr_wr, ret_conflict;

    // Only MIE/MPIE are stored; MPP is hardwired to M-mode.
    function automatic logic [XLEN-1:0] mstatus_view(input logic m_ie, input logic m_pie);
        logic [XLEN-1:0] v;
        v        = '0;
        v[3]     = m_ie;
        v[7]     = m_pie;
        v[12:11] = 2'b11;
        return v;
    endfunction

    function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] v);
        return {v[XLEN-1:2], 2'b00};
    endfunction

    always_comb begin
        csr_hit   = 1'b1;
        csr_rdata = '0;
        unique case (bus.i_csr_addr)
            ADDR_MSTATUS:  csr_rdata = mstatus_view(mie, mpie);
            ADDR_MTVEC:    csr_rdata = mtvec;
            ADDR_MSCRATCH: csr_rdata = mscratch;
            ADDR_MEPC:     csr_rdata = mepc;
            ADDR_MCAUSE:   csr_rdata = mcause;
            ADDR_MTVAL:    csr_rdata = mtval;
            default:       csr_hit   = 1'b0;
        endcase
    end

    assign bus.o_csr_rdata   = csr_rdata;
    assign bus.o_csr_illegal = (bus.i_csr_we | bus.i_csr_re) & ~csr_hit;
    assign bus.o_mie         = mie;

    // A trap wins over MRET and CSR writes; MRET wins over writes to the CSRs it consumes.
    assign is_idle      = (state == IDLE);
    assign take_trap    = is_idle & bus.i_exception;
    assign take_ret     = is_idle & bus.i_mret & ~bus.i_exception;
    assign ret_conflict = take_ret & ((bus.i_csr_addr == ADDR_MSTATUS) |
                                      (bus.i_csr_addr == ADDR_MEPC));
    assign csr_wr       = is_idle & bus.i_csr_we & csr_hit & ~bus.i_exception & ~ret_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) begin
            if (take_trap)     state_nxt = ENTER;
            else if (take_ret) state_nxt = RETURN;
        end
    end

    always_comb begin
        bus.o_redirect    = 1'b0;
        bus.o_flush       = 1'b0;
        bus.o_stall       = 1'b0;
        bus.o_redirect_pc = '0;
        unique case (state)
            ENTER: begin
                bus.o_redirect    = 1'b1;
                bus.o_flush       = 1'b1;
                bus.o_stall       = 1'b1;
                bus.o_redirect_pc = align4(mtvec);
            end
            RETURN: begin
                bus.o_redirect    = 1'b1;
                bus.o_flush       = 1'b1;
                bus.o_stall       = 1'b1;
                bus.o_redirect_pc = mepc;
            end
            default: ;
        endcase
    end

    // ---- CSR state update stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= align4(RESET_MTVEC);
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (take_trap) begin
            mepc   <= align4(bus.i_pc);
            mcause <= bus.i_mcause;
            mtval  <= bus.i_tval;
            mpie   <= mie;
            mie    <= 1'b0;
        end else begin
            if (take_ret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
            if (csr_wr) begin
                unique case (bus.i_csr_addr)
                    ADDR_MSTATUS: begin
                        mie  <= bus.i_csr_wdata[3];
                        mpie <= bus.i_csr_wdata[7];
                    end
                    ADDR_MTVEC:    mtvec    <= align4(bus.i_csr_wdata);
                    ADDR_MSCRATCH: mscratch <= bus.i_csr_wdata;
                    ADDR_MEPC:     mepc     <= align4(bus.i_csr_wdata);
                    ADDR_MCAUSE:   mcause   <= bus.i_csr_wdata;
                    ADDR_MTVAL:    mtval    <= bus.i_csr_wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_csr_unit.sv
// Scoreboard bench for trap_csr_unit: stimulus queues expected CSR reads and redirects,
// a negedge monitor pops and compares whenever the DUT presents a read or a redirect.
module tb_trap_csr_unit;
    localparam int XLEN = 32;

    typedef struct {
        string      name;
        logic [31:0] data;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t rd_q[$];
    exp_t rdr_q[$];

    trap_csr_if #(.XLEN(XLEN)) ifc ();

    trap_csr_unit #(.XLEN(XLEN), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        ifc.i_exception = 1'b0; ifc.i_mcause = '0; ifc.i_pc = '0; ifc.i_tval = '0;
        ifc.i_mret = 1'b0; ifc.i_csr_we = 1'b0; ifc.i_csr_re = 1'b0;
        ifc.i_csr_addr = '0; ifc.i_csr_wdata = '0;
    endtask

    // One cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic drive(input logic exc, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic mret, input logic we,
                         input logic re, input logic [11:0] addr, input logic [31:0] wd);
        ifc.i_exception = exc; ifc.i_mcause = cause; ifc.i_pc = pc; ifc.i_tval = tval;
        ifc.i_mret = mret; ifc.i_csr_we = we; ifc.i_csr_re = re;
        ifc.i_csr_addr = addr; ifc.i_csr_wdata = wd;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 12'h000, 0);
    endtask

    task automatic csr_read(input string name, input logic [11:0] addr,
                            input logic [31:0] exp, input logic ill);
        rd_q.push_back('{name, exp, ill});
        drive(0, 0, 0, 0, 0, 0, 1, addr, 0);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] wd);
        drive(0, 0, 0, 0, 0, 1, 0, addr, wd);
    endtask

    task automatic expect_redirect(input string name, input logic [31:0] pc);
        rdr_q.push_back('{name, pc, 1'b0});
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ifc.i_csr_re) begin
                if (rd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_read: addr 0x%03h with no expectation", ifc.i_csr_addr);
                end else begin
                    e = rd_q.pop_front();
                    check({e.name, "_rdata"}, ifc.o_csr_rdata, e.data);
                    check({e.name, "_illegal"}, {31'b0, ifc.o_csr_illegal}, {31'b0, e.ill});
                end
            end
            if (!rst && ifc.o_redirect) begin
                if (rdr_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h required no redirect",
                             ifc.o_redirect_pc);
                end else begin
                    e = rdr_q.pop_front();
                    check({e.name, "_pc"}, ifc.o_redirect_pc, e.data);
                    check({e.name, "_flush_stall"}, {30'b0, ifc.o_flush, ifc.o_stall}, 32'h3);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect", {31'b0, ifc.o_redirect}, 32'h0);
        check("rst_flush", {31'b0, ifc.o_flush}, 32'h0);
        check("rst_stall", {31'b0, ifc.o_stall}, 32'h0);
        check("rst_redirect_pc", ifc.o_redirect_pc, 32'h0);
        check("rst_mie", {31'b0, ifc.o_mie}, 32'h0);
        rst = 1'b0;
        idle_cycle();

        csr_read("rst_mtvec", 12'h305, 32'h0000_0100, 1'b0);
        csr_read("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        csr_read("illegal_7c0", 12'h7C0, 32'h0, 1'b1);

        csr_write(12'h300, 32'hFFFF_FFFF);
        check("mie_after_write", {31'b0, ifc.o_mie}, 32'h1);
        csr_read("mstatus_mask", 12'h300, 32'h0000_1888, 1'b0);

        csr_write(12'h305, 32'h0000_0203);
        csr_read("mtvec_align", 12'h305, 32'h0000_0200, 1'b0);
        csr_write(12'h305, 32'h0000_0101);
        csr_read("mtvec_back", 12'h305, 32'h0000_0100, 1'b0);

        csr_write(12'h340, 32'hA5A5_5A5A);
        rd_q.push_back('{"mscratch_rd_during_wr", 32'hA5A5_5A5A, 1'b0});
        drive(0, 0, 0, 0, 0, 1, 1, 12'h340, 32'h0000_1234);
        csr_read("mscratch_new", 12'h340, 32'h0000_1234, 1'b0);

        // Trap entry; the ENTER cycle carries a second exception and a write that must be ignored.
        expect_redirect("trap_redirect", 32'h0000_0100);
        drive(1, 32'd2, 32'h0000_1006, 32'h0000_DEAD, 0, 0, 0, 12'h000, 0);
        rd_q.push_back('{"mepc_in_enter", 32'h0000_1004, 1'b0});
        drive(1, 32'd7, 32'h0000_2000, 32'h0, 1, 1, 1, 12'h341, 32'h0000_FFFF);
        csr_read("trap_mepc", 12'h341, 32'h0000_1004, 1'b0);
        csr_read("trap_mcause", 12'h342, 32'h0000_0002, 1'b0);
        csr_read("trap_mtval", 12'h343, 32'h0000_DEAD, 1'b0);
        csr_read("trap_mstatus", 12'h300, 32'h0000_1880, 1'b0);
        check("trap_mie", {31'b0, ifc.o_mie}, 32'h0);

        expect_redirect("mret_redirect", 32'h0000_1004);
        drive(0, 0, 0, 0, 1, 0, 0, 12'h000, 0);
        idle_cycle();
        csr_read("mret_mstatus", 12'h300, 32'h0000_1888, 1'b0);
        check("mret_mie", {31'b0, ifc.o_mie}, 32'h1);

        expect_redirect("combo_redirect", 32'h0000_0100);
        drive(1, 32'h0000_000B, 32'h0000_3000, 32'h0, 1, 1, 0, 12'h340, 32'h0000_5555);
        idle_cycle();
        csr_read("combo_mscratch", 12'h340, 32'h0000_1234, 1'b0);
        csr_read("combo_mcause", 12'h342, 32'h0000_000B, 1'b0);
        csr_read("combo_mepc", 12'h341, 32'h0000_3000, 1'b0);
        csr_read("combo_mstatus", 12'h300, 32'h0000_1880, 1'b0);

        expect_redirect("mret_wr_redirect", 32'h0000_3000);
        drive(0, 0, 0, 0, 1, 1, 0, 12'h341, 32'h0000_4000);
        idle_cycle();
        csr_read("mret_wr_mepc", 12'h341, 32'h0000_3000, 1'b0);
        csr_read("mret_wr_mstatus", 12'h300, 32'h0000_1888, 1'b0);

        // Reset asserted while in ENTER: the redirect must never appear.
        csr_write(12'h340, 32'h0000_0077);
        csr_write(12'h305, 32'h0000_0400);
        drive(1, 32'd5, 32'h0000_5008, 32'h0000_BEEF, 0, 0, 0, 12'h000, 0);
        rst = 1'b1;
        #1;
        check("abort_redirect", {31'b0, ifc.o_redirect}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
        csr_read("abort_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        csr_read("abort_mtvec", 12'h305, 32'h0000_0100, 1'b0);
        csr_read("abort_mscratch", 12'h340, 32'h0, 1'b0);
        csr_read("abort_mepc", 12'h341, 32'h0, 1'b0);
        csr_read("abort_mcause", 12'h342, 32'h0, 1'b0);
        csr_read("abort_mtval", 12'h343, 32'h0, 1'b0);
        check("abort_mie", {31'b0, ifc.o_mie}, 32'h0);

        repeat (3) idle_cycle();
        check("pending_reads", rd_q.size(), 32'd0);
        check("pending_redirects", rdr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
